// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter: access sizes,
// requester ids, FSM states and small alignment/masking helpers.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MEM_BYTE  = 2'd0;
    localparam logic [1:0] MEM_HALF  = 2'd1;
    localparam logic [1:0] MEM_WORD  = 2'd2;
    localparam logic [1:0] MEM_DWORD = 2'd3;

    localparam logic [1:0] RAM_NOWRITE = 2'd3;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic bad;
        case (size)
            MEM_HALF:  bad = addr_lo[0];
            MEM_WORD:  bad = |addr_lo[1:0];
            MEM_DWORD: bad = |addr_lo;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    // A doubleword beat keeps all 32 bits, exactly like a word.
    function automatic logic [31:0] mask_read(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] masked;
        case (size)
            MEM_BYTE: masked = {24'b0, data[7:0]};
            MEM_HALF: masked = {16'b0, data[15:0]};
            default:  masked = data;
        endcase
        return masked;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the favoured requester wins, and every
// accepted grant hands the preference to the other side.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FETCH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic prio_q, prio_d;

    always_comb begin
        gnt    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            gnt = (prio_q == REQ_D) ? 2'b10 : 2'b01;
        end
        if (advance && (|gnt)) begin
            prio_d = gnt[REQ_IF] ? REQ_D : REQ_IF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= FETCH_FIRST ? REQ_IF : REQ_D;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported RAM between instruction fetch and load/store,
// splitting doubleword accesses into two 32-bit beats and acking the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          FETCH_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_ack,
    output logic [63:0]       d_rdata,
    output logic              d_err,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_data_i,
    output logic [1:0]        ram_mem_size,
    input  logic [31:0]       ram_data_o
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0] gnt;
    logic       advance;

    rr_arbiter2 #(
        .FETCH_FIRST(FETCH_FIRST)
    ) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({d_req, if_req}),
        .advance(advance),
        .gnt    (gnt)
    );

    // The RAM only ever sees a write size during a beat; IDLE and DONE park it
    // at RAM_NOWRITE so an abandoned or misaligned access cannot corrupt memory.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        advance      = 1'b0;
        ram_addr     = '0;
        ram_data_i   = '0;
        ram_mem_size = RAM_NOWRITE;
        if_ack       = 1'b0;
        d_ack        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    advance = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (gnt[REQ_IF]) begin
                        owner_d = REQ_IF;
                        addr_d  = if_addr;
                        size_d  = MEM_WORD;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        state_d = ST_BEAT0;
                    end else begin
                        owner_d = REQ_D;
                        addr_d  = d_addr;
                        size_d  = d_size;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (is_misaligned(d_size, d_addr[2:0])) begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_BEAT0;
                        end
                    end
                end
            end
            ST_BEAT0: begin
                ram_addr   = 32'(addr_q);
                ram_data_i = wdata_q[31:0];
                if (we_q) begin
                    ram_mem_size = (size_q == MEM_DWORD) ? MEM_WORD : size_q;
                end
                rdata_d = {32'b0, mask_read(size_q, ram_data_o)};
                state_d = (size_q == MEM_DWORD) ? ST_BEAT1 : ST_DONE;
            end
            ST_BEAT1: begin
                ram_addr   = 32'(addr_q) + 32'd4;
                ram_data_i = wdata_q[63:32];
                if (we_q) begin
                    ram_mem_size = MEM_WORD;
                end
                rdata_d[63:32] = ram_data_o;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if_ack  = (owner_q == REQ_IF);
                d_ack   = (owner_q == REQ_D);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_IF;
            addr_q  <= '0;
            size_q  <= MEM_BYTE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign if_rdata = rdata_q[31:0];
    assign d_rdata  = we_q ? 64'b0 : rdata_q;
    assign d_err    = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported simulation RAM between the instruction-fetch unit and the load/store unit of the RV64F core.
- Arbitrates round-robin between the two requesters and latches each request.
- Drives the RAM address, write-data and mem_size lines; captures RAM read data.
- Splits 64-bit doubleword accesses (ld/sd/fld/fsd) into two sequential 32-bit RAM beats.
- Returns a one-cycle ack to the granted requester.

Parameters:
- ADDR_W, 32: width of all addresses.
- FETCH_FIRST, 1: requester preferred on the first contended grant after reset (1 = fetch, 0 = data).

Ports:
- clk  in  1  core clock; also drives RAM mem_clk (RAM writes on posedge)
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 byte, 1 half, 2 word, 3 doubleword
- d_addr  in  ADDR_W  data address
- d_wdata  in  64  store data, LSB-aligned
- d_ack  out  1  one-cycle pulse; d_rdata and d_err valid this cycle
- d_rdata  out  64  load data: zero-extended for byte/half/word, full 64 bits for doubleword
- d_err  out  1  misaligned access; qualified by d_ack
- ram_addr  out  32  to RAM addr
- ram_data_i  out  32  to RAM data_i
- ram_mem_size  out  2  to RAM mem_size; 0/1/2 write byte/half/word, 3 = no write
- ram_data_o  in  32  from RAM data_o (combinational read)

Behaviour:
- Reset state (asynchronous, takes effect immediately, including mid-access):
  - state IDLE; ram_mem_size=3; ram_addr=0; ram_data_i=0.
  - if_ack=0, d_ack=0, d_err=0; if_rdata=0, d_rdata=0.
  - Round-robin pointer set to FETCH_FIRST.
  - An in-flight access is abandoned with no ack. The RAM sees mem_size=3 from the reset instant, so no partial write occurs after reset.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE (ram_mem_size=3):
  - Sample requests. Only one request asserted: grant it. Both asserted: grant the requester not granted last; the pointer updates on every grant.
  - On grant, latch owner, addr, size (fetch forces size=2, we=0), we and wdata.
  - Misaligned data request (half with addr[0]!=0, word with addr[1:0]!=0, doubleword with addr[2:0]!=0): go to DONE with err set. No RAM access.
  - Otherwise go to BEAT0.
- BEAT0:
  - ram_addr = latched addr.
  - ram_data_i = wdata[31:0].
  - ram_mem_size = we ? (size==3 ? 2 : size) : 3.
  - At the clock edge, capture ram_data_o masked to size into rdata[31:0].
  - Next state: size==3 goes to BEAT1, else DONE.
- BEAT1 (doubleword only):
  - ram_addr = addr+4 (wraps mod 2^32); ram_data_i = wdata[63:32]; ram_mem_size = we ? 2 : 3.
  - Capture ram_data_o into rdata[63:32]. Next state DONE.
- DONE (ram_mem_size=3):
  - Assert the owner's ack for exactly one cycle, with rdata (d_err for the data port) valid. The other ack stays 0. Next state IDLE.
- Latency, aligned access from a grant in IDLE cycle N:
  - byte/half/word ack in cycle N+2.
  - doubleword ack in cycle N+3.
  - misaligned ack in cycle N+1.
- Handshake rules:
  - The requester holds req and its operands stable until ack.
  - The requester deasserts req in the cycle after ack, unless it issues a new request.
  - The arbiter samples req only in IDLE, so back-to-back requests cost one IDLE cycle each.
- Read masking for loads: byte → [7:0], half → [15:0], word → [31:0]; upper bits 0. Stores leave d_rdata unchanged-don't-care but are driven 0.
- A request arriving during BEAT0/BEAT1/DONE waits. The round-robin pointer guarantees the waiting requester is granted next.

Decomposition:
- Shared package/include (mem_defs):
  - size encodings MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2, MEM_DWORD=3.
  - RAM_NOWRITE=3.
  - state encodings.
  - Requester ids REQ_IF=0, REQ_D=1.
- One sub-module: rr_arbiter2, a 2-input round-robin grant with pointer register (clk, reset, req[1:0], advance → gnt[1:0]).
- Beat sequencing, masking and alignment checks stay in mem_port_arbiter.

Test Plan:
- Fetch only: if_req, if_addr=0x100, RAM[0x100..0x103]=13 05 A0 00 → if_ack two cycles after grant, if_rdata=0x00A00513; ram_mem_size stays 3 throughout.
- Doubleword store: d_we=1, d_size=3, d_addr=0x200, d_wdata=0x1122334455667788 → RAM[0x200..0x207]=88 77 66 55 44 33 22 11. Then a doubleword load at 0x200 returns d_rdata=0x1122334455667788 with ack at grant+3.
- Contention: if_req and d_req both held continuously from reset with FETCH_FIRST=1 → grant order IF, D, IF, D; no requester waits more than one transaction.
- Byte store/load: store size 0 at 0x301 with data 0xFFFFFFFFFFFFFFAB → only RAM[0x301]=AB changes. Load size 0 at 0x301 returns 0x00000000000000AB.
- Misaligned: d_size=2, d_addr=0x202, d_we=1 → d_ack with d_err=1 one cycle after grant; RAM unchanged; ram_mem_size never leaves 3.
- Reset during BEAT0 of a doubleword store → outputs return to reset values immediately; no ack; RAM[0x204..0x207] unchanged. The next request after reset release is served normally.
